// File: rtl/icm42688_spi_periph.sv
// icm42688_spi_periph
// SPI mode-0 responder that emulates the ICM-42688 register interface, used in
// place of the real sensor for hardware-in-loop and loopback self-test builds.
// A 128-byte register file supports burst read/write with address auto-increment.
// Sensor data registers 0x1D-0x2A are read-only and are loaded from the parallel
// inputs when chip select is asserted.
//
// Ports:
//   clk_i, rst_ni              system clock, async active-low reset
//   spi_sck_i/cs_n_i/mosi_i    SPI pins from the master (oversampled in clk_i)
//   spi_miso_o                 peripheral-out data
//   temp_i, accel_*_i, gyro_*_i  16-bit signed sensor samples
//   whoami_force_bad_i         makes register 0x75 read 8'hFF
//   wr_strobe_o/addr_o/data_o  one-cycle report of each committed write byte
//   busy_o                     high while synchronized CS_n is low
module icm42688_spi_periph #(
  parameter logic [7:0]  WHOAMI_VAL  = 8'h47,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_sck_i,
  input  logic        spi_cs_n_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  input  logic [15:0] temp_i,
  input  logic [15:0] accel_x_i,
  input  logic [15:0] accel_y_i,
  input  logic [15:0] accel_z_i,
  input  logic [15:0] gyro_x_i,
  input  logic [15:0] gyro_y_i,
  input  logic [15:0] gyro_z_i,
  input  logic        whoami_force_bad_i,
  output logic        wr_strobe_o,
  output logic [6:0]  wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o
);

  localparam logic [6:0] AddrWhoami = 7'h75;
  localparam logic [6:0] AddrSnapLo = 7'h1D;
  localparam logic [6:0] AddrSnapHi = 7'h2A;

  typedef enum logic [1:0] {StIdle, StCmd, StRd, StWr} state_e;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] r_sck_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sck_prev, r_cs_prev;
  logic                   w_sck, w_mosi, w_cs_n;
  logic                   w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1; // idle-high so reset never looks like a CS fall
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev;
  assign w_sck_fall = ~w_sck & r_sck_prev;
  assign w_cs_fall  = ~w_cs_n & r_cs_prev;
  assign w_cs_rise  = w_cs_n & ~r_cs_prev;

  // State
  state_e      r_state, w_state_next;
  logic [2:0]  r_bit_cnt, w_bit_cnt_next;
  logic [6:0]  r_addr, w_addr_next;
  logic [7:0]  r_tx, w_tx_next;
  logic [7:0]  r_rx, w_rx_next;
  logic [7:0]  r_regs [128];
  logic        r_wr_strobe;
  logic [6:0]  r_wr_addr;
  logic [7:0]  r_wr_data;

  logic        w_last_bit, w_commit, w_snapshot;
  logic [7:0]  w_rx_byte;
  logic [6:0]  w_addr_inc;
  logic [7:0]  w_rd_cmd, w_rd_inc;

  function automatic logic is_writable(input logic [6:0] a);
    return !((a == AddrWhoami) || ((a >= AddrSnapLo) && (a <= AddrSnapHi)));
  endfunction

  assign w_last_bit = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_rx_byte  = {r_rx[6:0], w_mosi};
  assign w_addr_inc = r_addr + 7'd1;

  // Read data for the command address and for the next burst address
  assign w_rd_cmd = ((w_rx_byte[6:0] == AddrWhoami) && whoami_force_bad_i) ? 8'hFF
                                                                           : r_regs[w_rx_byte[6:0]];
  assign w_rd_inc = ((w_addr_inc == AddrWhoami) && whoami_force_bad_i) ? 8'hFF
                                                                       : r_regs[w_addr_inc];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_bit_cnt <= 3'd0;
      r_addr    <= 7'd0;
      r_tx      <= 8'd0;
      r_rx      <= 8'd0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_addr    <= w_addr_next;
      r_tx      <= w_tx_next;
      r_rx      <= w_rx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_addr_next    = r_addr;
    w_tx_next      = r_tx;
    w_rx_next      = r_rx;
    w_commit       = 1'b0;
    w_snapshot     = 1'b0;
    // CS rise is checked first so it beats a coincident 8th SCK rise
    if (w_cs_rise) begin
      w_state_next   = StIdle;
      w_bit_cnt_next = 3'd0;
    end else if (w_cs_fall) begin
      w_snapshot     = 1'b1;
      w_bit_cnt_next = 3'd0;
      w_state_next   = StCmd;
    end else begin
      unique case (r_state)
        StIdle: ;
        StCmd: begin
          if (w_sck_rise) begin
            w_rx_next      = w_rx_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              w_addr_next = w_rx_byte[6:0];
              if (w_rx_byte[7]) begin
                w_tx_next    = w_rd_cmd;
                w_state_next = StRd;
              end else begin
                w_state_next = StWr;
              end
            end
          end
        end
        StRd: begin
          // No shift on the first fall of a byte: the MSB was loaded by the reload
          if (w_sck_fall && (r_bit_cnt != 3'd0)) w_tx_next = {r_tx[6:0], 1'b0};
          if (w_sck_rise) begin
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              w_addr_next = w_addr_inc;
              w_tx_next   = w_rd_inc;
            end
          end
        end
        StWr: begin
          if (w_sck_rise) begin
            w_rx_next      = w_rx_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (w_last_bit) begin
              w_addr_next = w_addr_inc;
              w_commit    = is_writable(r_addr);
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Register file: snapshot at CS fall, commits from write bursts
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 128; i++) begin
        r_regs[i] <= (i == 32'h75) ? WHOAMI_VAL : 8'h00;
      end
    end else if (w_snapshot) begin
      r_regs[7'h1D] <= temp_i[15:8];
      r_regs[7'h1E] <= temp_i[7:0];
      r_regs[7'h1F] <= accel_x_i[15:8];
      r_regs[7'h20] <= accel_x_i[7:0];
      r_regs[7'h21] <= accel_y_i[15:8];
      r_regs[7'h22] <= accel_y_i[7:0];
      r_regs[7'h23] <= accel_z_i[15:8];
      r_regs[7'h24] <= accel_z_i[7:0];
      r_regs[7'h25] <= gyro_x_i[15:8];
      r_regs[7'h26] <= gyro_x_i[7:0];
      r_regs[7'h27] <= gyro_y_i[15:8];
      r_regs[7'h28] <= gyro_y_i[7:0];
      r_regs[7'h29] <= gyro_z_i[15:8];
      r_regs[7'h2A] <= gyro_z_i[7:0];
    end else if (w_commit) begin
      r_regs[r_addr] <= w_rx_byte;
    end
  end

  // Write report, one clk_i after the synchronized 8th rise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= 7'd0;
      r_wr_data   <= 8'd0;
    end else begin
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_rx_byte;
      end
    end
  end

  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign busy_o      = ~w_cs_n;
  assign spi_miso_o  = (r_state == StRd) & r_tx[7];

endmodule

// File: tb/tb_icm42688_spi_periph.sv
// Directed bench for icm42688_spi_periph: a bit-banged SPI mode-0 master with a
// scoreboard of expected MISO bytes and expected write commits.
module tb_icm42688_spi_periph;

  localparam int HALF = 8; // SCK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] temp = '0, ax = '0, ay = '0, az = '0, gx = '0, gy = '0, gz = '0;
  logic        force_bad = 1'b0;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;

  int tests_run = 0;
  int n_fail = 0;
  int strobe_cnt = 0;
  int mutate_after = -1;

  logic [7:0]  tx_q[$];
  logic [7:0]  exp_q[$];
  logic [14:0] wr_q[$];

  always #5 clk = ~clk;

  icm42688_spi_periph #(
    .WHOAMI_VAL (8'h47),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .spi_sck_i         (spi_sck),
    .spi_cs_n_i        (spi_cs_n),
    .spi_mosi_i        (spi_mosi),
    .spi_miso_o        (spi_miso),
    .temp_i            (temp),
    .accel_x_i         (ax),
    .accel_y_i         (ay),
    .accel_z_i         (az),
    .gyro_x_i          (gx),
    .gyro_y_i          (gy),
    .gyro_z_i          (gz),
    .whoami_force_bad_i(force_bad),
    .wr_strobe_o       (wr_strobe),
    .wr_addr_o         (wr_addr),
    .wr_data_o         (wr_data),
    .busy_o            (busy)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Commit monitor: each strobe pops the next expected (addr, data)
  always @(negedge clk) begin
    if (rst_n && wr_strobe) begin
      strobe_cnt++;
      tests_run++;
      assert (wr_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_strobe: observed addr %h data %h expected no commit",
               wr_addr, wr_data);
      end
      if (wr_q.size() != 0) check("wr_commit", {1'b0, wr_addr, wr_data}, {1'b0, wr_q.pop_front()});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      wait_clk(HALF);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      wait_clk(HALF);
      spi_sck = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] tx, input logic [7:0] exp);
    tx_q.push_back(tx);
    exp_q.push_back(exp);
  endtask

  task automatic mutate();
    temp = 16'hAAAA; ax = 16'h5555; ay = 16'h0F0F; az = 16'hF0F0;
    gx = 16'h1111;   gy = 16'h2222; gz = 16'h3333;
  endtask

  // One full transaction over everything queued in tx_q
  task automatic xfer();
    logic [7:0] rx;
    int n;
    n = tx_q.size();
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < n; i++) begin
      spi_bits(tx_q.pop_front(), 8, rx);
      if (i == mutate_after) mutate();
      tests_run++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL rd_underflow: observed %h expected nothing queued", rx);
      end
      if (exp_q.size() != 0) check("miso_byte", {8'h00, rx}, {8'h00, exp_q.pop_front()});
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
  endtask

  initial begin
    logic [15:0] sens [7];
    logic [7:0]  rx;
    int          sc;

    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    check("rst_miso", {15'd0, spi_miso}, 16'd0);
    check("rst_strobe", {15'd0, wr_strobe}, 16'd0);
    check("rst_addr", {9'd0, wr_addr}, 16'd0);
    check("rst_data", {8'd0, wr_data}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);

    // WHO_AM_I, normal and forced bad
    push(8'hF5, 8'h00); push(8'h00, 8'h47); xfer();
    force_bad = 1'b1;
    push(8'hF5, 8'h00); push(8'h00, 8'hFF); xfer();
    force_bad = 1'b0;

    // Busy follows CS
    spi_cs_n = 1'b0; wait_clk(4);
    check("busy_cs_low", {15'd0, busy}, 16'd1);
    spi_cs_n = 1'b1; wait_clk(4);
    check("busy_cs_high", {15'd0, busy}, 16'd0);

    // Burst sensor read; inputs change mid-burst, snapshot must hold
    temp = 16'h0064; ax = 16'h1234; ay = 16'h5678; az = 16'h9ABC;
    gx = 16'hDEF0;   gy = 16'h1357; gz = 16'h2468;
    sens = '{temp, ax, ay, az, gx, gy, gz};
    push(8'h9D, 8'h00);
    for (int i = 0; i < 7; i++) begin
      push(8'h00, sens[i][15:8]);
      push(8'h00, sens[i][7:0]);
    end
    mutate_after = 4;
    xfer();
    mutate_after = -1;

    // Write burst then read back
    wr_q.push_back({7'h4E, 8'h0F}); wr_q.push_back({7'h4F, 8'h06});
    push(8'h4E, 8'h00); push(8'h0F, 8'h00); push(8'h06, 8'h00); xfer();
    check("wr_pending_4e", wr_q.size(), 16'd0);
    push(8'hCE, 8'h00); push(8'h00, 8'h0F); push(8'h00, 8'h06); xfer();

    // Read-only protection
    sc = strobe_cnt;
    push(8'h75, 8'h00); push(8'hAA, 8'h00); xfer();
    push(8'h1F, 8'h00); push(8'hAA, 8'h00); xfer();
    check("ro_no_strobe", strobe_cnt - sc, 16'd0);
    push(8'hF5, 8'h00); push(8'h00, 8'h47); xfer();
    push(8'h9F, 8'h00); push(8'h00, ax[15:8]); push(8'h00, ax[7:0]); xfer();

    // Address wrap 0x7F -> 0x00
    wr_q.push_back({7'h7F, 8'h11}); wr_q.push_back({7'h00, 8'h22});
    push(8'h7F, 8'h00); push(8'h11, 8'h00); push(8'h22, 8'h00); xfer();
    check("wr_pending_wrap", wr_q.size(), 16'd0);
    push(8'hFF, 8'h00); push(8'h00, 8'h11); push(8'h00, 8'h22); xfer();

    // Abort after 4 data bits: no commit, MISO low, next transaction normal
    sc = strobe_cnt;
    spi_cs_n = 1'b0; wait_clk(HALF);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h5A, 4, rx);
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(2 * HALF);
    check("abort_no_strobe", strobe_cnt - sc, 16'd0);
    check("abort_miso", {15'd0, spi_miso}, 16'd0);
    wr_q.push_back({7'h10, 8'h5A});
    push(8'h10, 8'h00); push(8'h5A, 8'h00); xfer();
    push(8'h90, 8'h00); push(8'h00, 8'h5A); xfer();
    check("wr_pending_abort", wr_q.size(), 16'd0);

    // Reset mid-transaction restores register contents and outputs
    spi_cs_n = 1'b0; wait_clk(HALF);
    spi_bits(8'h4E, 8, rx);
    spi_bits(8'h33, 4, rx);
    rst_n = 1'b0;
    wait_clk(2);
    check("midrst_miso", {15'd0, spi_miso}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_strobe", {15'd0, wr_strobe}, 16'd0);
    spi_cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    push(8'hCE, 8'h00); push(8'h00, 8'h00); push(8'h00, 8'h00); xfer();
    push(8'hFF, 8'h00); push(8'h00, 8'h00); push(8'h00, 8'h00); xfer();
    push(8'hF5, 8'h00); push(8'h00, 8'h47); xfer();
    check("wr_pending_end", wr_q.size(), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
    $finish;
  end

endmodule
